// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared constants, state encoding and helper function for the
//               14-way round-robin arbiter (rr_arbiter_14 / rr_pick_14).
//               N_REQ : number of requesters (fixed at 14)
//               ID_W  : width of a binary requester index
//               state_t : arbiter state (IDLE = no owner, BUSY = owned)
//               onehot_to_id() : one-hot (or zero) vector -> binary index
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int N_REQ = 14;
    localparam int ID_W  = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // OR-accumulates the indices of set bits; exact for one-hot input and
    // returns 0 for an all-zero vector.
    function automatic logic [ID_W-1:0] onehot_to_id(input logic [N_REQ-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                id = id | ID_W'(i);
            end
        end
        return id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick_14.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick_14
// Description : Combinational round-robin picker. Scans the candidate set
//               (req with mask bits removed) starting at ptr and wrapping
//               past 13 to 0; reports the first set bit.
// Ports       : req       in  14  raw request vector
//               ptr       in  4   scan start index (0..13)
//               mask      in  14  bits excluded from the scan
//               win_valid out 1   a candidate exists
//               win_id    out 4   index of the winner (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick_14
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic [N_REQ-1:0] mask,
    output logic             win_valid,
    output logic [ID_W-1:0]  win_id
);

    localparam int c_IW = ID_W + 1;

    logic [N_REQ-1:0] w_cand;
    logic [N_REQ-1:0] w_win_oh;
    logic [c_IW-1:0]  w_idx;

    // Scan offsets from farthest to nearest so the last hit written is the
    // one closest to ptr; this avoids a loop break.
    always_comb begin
        w_cand   = req & ~mask;
        w_win_oh = '0;
        w_idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = {1'b0, ptr} + c_IW'(i);
            if (w_idx >= c_IW'(N_REQ)) begin
                w_idx = w_idx - c_IW'(N_REQ);
            end
            if (w_cand[w_idx[ID_W-1:0]]) begin
                w_win_oh = N_REQ'(1) << w_idx;
            end
        end
    end

    assign win_valid = |w_cand;
    assign win_id    = onehot_to_id(w_win_oh);

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_14.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_14
// Description : Round-robin arbiter for 14 requesters with a registered
//               one-hot grant held until the owner drops its request.
//               On release the next owner is picked in the same edge
//               (back-to-back grants). Optional tenure limit is enabled by
//               defining ARB_TIMEOUT_EN (parameter HOLD_MAX, 1..255).
// Ports       : clk         in  1   system clock
//               rst         in  1   synchronous active-high reset
//               req         in  14  level-sensitive request vector
//               any_req     out 1   combinational OR of req
//               grant       out 14  registered one-hot grant (or zero)
//               grant_valid out 1   registered, grant non-zero
//               grant_id    out 4   registered index of granted bit
//               timeout     out 1   one-cycle pulse on forced revocation
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_14
    import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int HOLD_MAX = 16
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic             any_req,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id,
    output logic             timeout
);

    state_t           r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [N_REQ-1:0] r_grant;
    logic             r_grant_valid;
    logic [ID_W-1:0]  r_grant_id;

    logic [N_REQ-1:0] w_mask;
    logic             w_owner_req;
    logic             w_win_valid;
    logic [ID_W-1:0]  w_win_id;
    logic [ID_W-1:0]  w_ptr_next;

    assign any_req = |req;

    // While BUSY the owner is excluded, so the same picker serves both
    // idle arbitration and release-time rearbitration.
    assign w_mask      = (r_state == BUSY) ? r_grant : '0;
    assign w_owner_req = |(req & r_grant);
    assign w_ptr_next  = (w_win_id == ID_W'(N_REQ - 1)) ? '0 : w_win_id + 1'b1;

    rr_pick_14 u_pick (
        .req       (req),
        .ptr       (r_ptr),
        .mask      (w_mask),
        .win_valid (w_win_valid),
        .win_id    (w_win_id)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(HOLD_MAX + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_cnt         <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if ((r_state == BUSY) && w_owner_req) begin
                if (r_cnt == c_CNT_W'(HOLD_MAX - 1)) begin
                    // Forced revocation; ptr already points past the owner.
                    r_state       <= IDLE;
                    r_grant       <= '0;
                    r_grant_valid <= 1'b0;
                    r_grant_id    <= '0;
                    r_timeout     <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_win_valid) begin
                r_state       <= BUSY;
                r_grant       <= N_REQ'(1) << w_win_id;
                r_grant_valid <= 1'b1;
                r_grant_id    <= w_win_id;
                r_ptr         <= w_ptr_next;
                r_cnt         <= '0;
            end else begin
                r_state       <= IDLE;
                r_grant       <= '0;
                r_grant_valid <= 1'b0;
                r_grant_id    <= '0;
            end
        end
    end

    assign timeout = r_timeout;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
        end else begin
            if ((r_state == BUSY) && w_owner_req) begin
                // Owner keeps the resource regardless of other requests.
                r_state <= BUSY;
            end else if (w_win_valid) begin
                r_state       <= BUSY;
                r_grant       <= N_REQ'(1) << w_win_id;
                r_grant_valid <= 1'b1;
                r_grant_id    <= w_win_id;
                r_ptr         <= w_ptr_next;
            end else begin
                r_state       <= IDLE;
                r_grant       <= '0;
                r_grant_valid <= 1'b0;
                r_grant_id    <= '0;
            end
        end
    end

    assign timeout = 1'b0;
`endif

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_14.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_14
// Description : Directed self-checking bench for rr_arbiter_14. Inputs are
//               driven 1 time unit after the rising edge and outputs are
//               checked there, away from the active edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_14;

    localparam logic [13:0] c_ALL = 14'h3FFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] req = '0;
    logic        any_req;
    logic [13:0] grant;
    logic        grant_valid;
    logic [3:0]  grant_id;
    logic        timeout;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
    rr_arbiter_14 #(.HOLD_MAX(4)) dut (
`else
    rr_arbiter_14 dut (
`endif
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .any_req     (any_req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full check of the registered outputs for an expected owner (or none).
    task automatic chk_grant(input string tag, input logic vld, input int id);
        logic [13:0] exp_g;
        exp_g = vld ? (14'd1 << id) : 14'd0;
        chk({tag, ".grant"}, {2'b0, grant}, {2'b0, exp_g});
        chk({tag, ".valid"}, {15'b0, grant_valid}, {15'b0, vld});
        chk({tag, ".id"}, {12'b0, grant_id}, vld ? 16'(id) : 16'd0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        req = '0;
        step();
        step();
        rst = 1'b0;
        chk_grant("reset", 1'b0, 0);
        chk("reset.timeout", {15'b0, timeout}, 16'd0);
        chk("reset.any_req", {15'b0, any_req}, 16'd0);

        // Single request, one-cycle latency, any_req combinational
        req = 14'h0001;
        #1;
        chk("req0.any_req", {15'b0, any_req}, 16'd1);
        chk("req0.pre_grant", {2'b0, grant}, 16'd0);
        step();
        chk_grant("req0", 1'b1, 0);

        // All requesting; each owner drops for one cycle -> 1,2,..,13,0
        for (int k = 1; k <= 14; k++) begin
            req = c_ALL & ~(14'd1 << ((k - 1) % 14));
            step();
            chk_grant($sformatf("rr%0d", k), 1'b1, k % 14);
        end

        // Go idle (ptr = 1), then owner 5 holds against req[7]
        req = '0;
        step();
        chk_grant("idle1", 1'b0, 0);
        req = 14'h0001 << 5;
        step();
        chk_grant("own5", 1'b1, 5);
        req = (14'd1 << 5) | (14'd1 << 7);
        step();
        chk_grant("hold5a", 1'b1, 5);
        step();
        chk_grant("hold5b", 1'b1, 5);
        req = 14'd1 << 7;
        step();
        chk_grant("rel5", 1'b1, 7);

        // Grant 12 (ptr -> 13), then bits 2 and 13: 13 first, then wrap to 2
        req = 14'd1 << 12;
        step();
        chk_grant("own12", 1'b1, 12);
        req = (14'd1 << 2) | (14'd1 << 13);
        step();
        chk_grant("wrap13", 1'b1, 13);
        req = 14'd1 << 2;
        step();
        chk_grant("wrap2", 1'b1, 2);

        // Idle (ptr = 3), grant 9, then reset mid-grant
        req = '0;
        step();
        chk_grant("idle2", 1'b0, 0);
        req = 14'd1 << 9;
        step();
        chk_grant("own9", 1'b1, 9);
        rst = 1'b1;
        step();
        chk_grant("rst9", 1'b0, 0);
        rst = 1'b0;
        req = 14'h0201;
        step();
        chk_grant("ptr_reset", 1'b1, 0);
        // Non-owner dropping its request changes nothing
        req = 14'h0001;
        step();
        chk_grant("drop_nonowner", 1'b1, 0);

`ifdef ARB_TIMEOUT_EN
        // HOLD_MAX=4: 4 granted cycles, timeout pulse, one gap, re-grant
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
        req = 14'h0008;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_grant($sformatf("to_hold%0d", c), 1'b1, 3);
            chk($sformatf("to_nopulse%0d", c), {15'b0, timeout}, 16'd0);
        end
        step();
        chk_grant("to_revoke", 1'b0, 0);
        chk("to_pulse", {15'b0, timeout}, 16'd1);
        step();
        chk_grant("to_regrant3", 1'b1, 3);
        chk("to_pulse_end", {15'b0, timeout}, 16'd0);
        req = 14'h0018;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_grant($sformatf("to2_hold%0d", c), 1'b1, 3);
        end
        step();
        chk_grant("to2_revoke", 1'b0, 0);
        chk("to2_pulse", {15'b0, timeout}, 16'd1);
        step();
        chk_grant("to2_grant4", 1'b1, 4);
`else
        // No tenure limit: owner 0 keeps the grant indefinitely
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("hold_id%0d", c), {12'b0, grant_id}, 16'd0);
            chk($sformatf("hold_valid%0d", c), {15'b0, grant_valid}, 16'd1);
            chk($sformatf("hold_to%0d", c), {15'b0, timeout}, 16'd0);
        end
`endif

        req = '0;
        step();
        chk_grant("final_idle", 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arbiter_14.md
Name: rr_arbiter_14

Overview:
- Round-robin arbiter sharing one resource among 14 requesters.
- Raw request vector is OR-reduced to an any-request flag, the same 14-input OR function used elsewhere in the design.
- Registered one-hot grant, held until the owner drops its request.
- Sits between the 14 requester blocks and the shared datapath resource; the grant drives that resource's input mux select.

Parameters:
- N_REQ, 14, number of requesters; fixed at 14 for this block, present for documentation and package use.
- HOLD_MAX, 16, maximum grant tenure in cycles; used only when ARB_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  14  request vector; bit i = requester i; level-sensitive.
- any_req  out  1  combinational OR of all 14 req bits; no register.
- grant  out  14  registered one-hot grant, or all zeros.
- grant_valid  out  1  registered; high when grant is non-zero.
- grant_id  out  4  registered binary index of the granted bit (0..13); 0 when grant_valid=0.
- timeout  out  1  registered one-cycle pulse on forced revocation; constant 0 when ARB_TIMEOUT_EN is undefined.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - grant = 0, grant_valid = 0, grant_id = 0, timeout = 0.
  - Pointer ptr = 0; state = IDLE; tenure counter = 0.
- States:
  - IDLE: no owner.
  - BUSY: owner = grant_id.
- IDLE -> BUSY:
  - Condition: any_req=1 at a clock edge.
  - Winner: first set bit scanning ptr, ptr+1, …, 13, 0, …, ptr-1.
  - At that edge: grant, grant_id and grant_valid load; ptr <= (winner+1) mod 14, so 13 wraps to 0.
- Latency: req sampled at edge t yields a visible grant after edge t. One cycle from request to grant.
- BUSY hold: while req[owner]=1, grant is unchanged, regardless of other requests.
- BUSY release (req[owner]=0 at an edge):
  - Rearbitrate in the same edge over req with the owner bit masked.
  - If a winner exists: grant switches directly to it (back-to-back, no idle cycle); ptr updates as above.
  - Otherwise: grant cleared and state returns to IDLE.
- Simultaneous requests: the pointer order alone decides. Lower index has no inherent priority.
- A requester dropping req while not granted has no effect.
- rst asserted mid-grant: the grant drops after that edge; state and pointer return to reset values.
- Invariants:
  - grant is always zero or exactly one bit.
  - grant_id always matches grant.
  - A granted bit always had req=1 at the edge that granted it.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Tenure counter, $clog2(HOLD_MAX+1) bits, clears on every new grant and increments each BUSY cycle.
  - When the count reaches HOLD_MAX-1 with req[owner] still 1: next edge clears grant, state -> IDLE, timeout pulses for one cycle.
  - ptr is already owner+1, so the revoked owner is re-granted only if no other requester is active. A mandatory one-cycle gap precedes that re-grant.
- Undefined:
  - No counter is instantiated and timeout is tied 0.
  - A grant may be held indefinitely.

Decomposition:
- Shared package arb_pkg holds:
  - constant N_REQ=14 and ID_W=4;
  - state enum {IDLE, BUSY};
  - function onehot_to_id(14-bit) -> 4-bit.
- One natural sub-module, rr_pick_14:
  - purely combinational; inputs req (14), ptr (4), mask (14); outputs win_valid and win_id.
  - Instantiated once and used both for IDLE arbitration and for the release-time rearbitration.
- The any_req OR stays inline.

Test Plan:
- Reset, then req=14'h0001 → after one edge grant=14'h0001, grant_id=0, grant_valid=1; any_req=1 combinationally in the same cycle.
- All 14 bits held high, each owner drops its req for one cycle after being granted → grant_id sequence 0,1,2,…,13,0 with no idle cycles between grants.
- ptr=13 (after granting 12), req bits 2 and 13 set → 13 granted; next arbitration wraps and grants 2.
- Owner 5 granted, req[7] rises, req[5] held → grant stays 5; req[5] drops → next edge grant_id=7.
- rst pulsed while grant_id=9 → next edge grant=0, grant_valid=0; with req=14'h0201 afterwards, grant_id=0 (ptr reset).
- ARB_TIMEOUT_EN, HOLD_MAX=4, req=14'h0008 held → grant valid for 4 cycles, timeout pulses for 1 cycle, 1 idle cycle, then re-grant 3; with req[4] also set, 4 is granted after the idle cycle instead.
